// File: rtl/addend_collector_pkg.sv
// Shared definitions for the addend collector: packing FSM encoding and
// the width helpers used to size the sum, the lane counter and the tree depth.
package addend_collector_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } fill_state_t;

  function automatic int calcClog2(input int value);
    return (value <= 1) ? 0 : $clog2(value);
  endfunction

  function automatic int sumWidth(input int dataWidth, input int length);
    return dataWidth + calcClog2(length);
  endfunction

endpackage

// File: rtl/addend_collector_if.sv
// Upstream addend stream and downstream result stream of the collector.
// The slave modport is the collector's view; master is the environment's view.
interface addend_collector_if
  import addend_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int OUT_WIDTH  = sumWidth(DATA_WIDTH, LENGTH),
  parameter int CNT_WIDTH  = calcClog2(LENGTH + 1)
);

  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic                         s_last;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [OUT_WIDTH-1:0]  m_sum;
  logic [CNT_WIDTH-1:0]         m_count;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_sum, m_count
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_sum, m_count
  );

endinterface

// File: rtl/addend_collector_tree.sv
// Pipelined balanced adder tree: one register level per tree level, stalled
// as a whole by in_advance. Lanes beyond LENGTH are padded with zero.
module AdderTreePipelined
  import addend_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int OUT_WIDTH  = sumWidth(DATA_WIDTH, LENGTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_advance,
  input  logic [LENGTH*DATA_WIDTH-1:0] in_data,
  output logic signed [OUT_WIDTH-1:0]  out_sum
);

  localparam int LATENCY = calcClog2(LENGTH);
  localparam int LEAVES  = 1 << LATENCY;
  localparam int EXT     = OUT_WIDTH - DATA_WIDTH;

  // Heap layout: node k sums children 2k and 2k+1; indices >= LEAVES are the
  // sign-extended input lanes, so the root (node 1) sits LATENCY registers deep.
  logic signed [OUT_WIDTH-1:0] r_node [1:LEAVES-1];
  logic signed [OUT_WIDTH-1:0] w_all  [2:2*LEAVES-1];

  always_comb begin
    for (int k = 2; k < LEAVES; k++) begin
      w_all[k] = r_node[k];
    end
    for (int i = 0; i < LEAVES; i++) begin
      w_all[LEAVES+i] = '0;
    end
    for (int i = 0; i < LENGTH; i++) begin
      w_all[LEAVES+i] = {{EXT{in_data[i*DATA_WIDTH+DATA_WIDTH-1]}},
                         in_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < LEAVES; k++) begin
        r_node[k] <= '0;
      end
    end else if (in_advance) begin
      for (int k = 1; k < LEAVES; k++) begin
        r_node[k] <= w_all[2*k] + w_all[2*k+1];
      end
    end
  end

  assign out_sum = r_node[1];

endmodule

// File: rtl/addend_collector.sv
// Packs signed addends into LENGTH-wide vectors (closable early with s_last)
// and sums each vector through a pipelined tree with a matching token line.
module addend_collector
  import addend_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int OUT_WIDTH  = sumWidth(DATA_WIDTH, LENGTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  addend_collector_if.slave bus
);

  localparam int LATENCY   = calcClog2(LENGTH);
  localparam int CNT_WIDTH = calcClog2(LENGTH + 1);

  fill_state_t                  r_state, w_stateNext;
  logic [CNT_WIDTH-1:0]         r_count, w_countNext, w_baseCount;
  logic [LENGTH*DATA_WIDTH-1:0] r_lanes, w_lanesNext;
  logic [LATENCY-1:0]           r_tokValid;
  logic [CNT_WIDTH-1:0]         r_tokCount [LATENCY];
  logic signed [OUT_WIDTH-1:0]  w_treeSum;
  logic                         w_advance, w_sReady, w_accept, w_launch, w_close;

  assign w_advance = !r_tokValid[LATENCY-1] || bus.m_ready;
  assign w_sReady  = (r_state != ST_READY) || w_advance;
  assign w_accept  = bus.s_valid && w_sReady;
  assign w_launch  = (r_state == ST_READY) && w_advance;

  // On a launch edge the buffer empties first, so a word accepted on the same
  // edge lands in lane 0 of the next vector and no bubble cycle is lost.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_lanesNext = r_lanes;
    w_baseCount = r_count;
    w_close     = 1'b0;
    if (w_launch) begin
      w_baseCount = '0;
      w_countNext = '0;
      w_lanesNext = '0;
      w_stateNext = ST_EMPTY;
    end
    if (w_accept) begin
      for (int i = 0; i < LENGTH; i++) begin
        if (w_baseCount == CNT_WIDTH'(i)) begin
          w_lanesNext[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
        end
      end
      w_countNext = w_baseCount + CNT_WIDTH'(1);
      w_close     = bus.s_last || (w_baseCount == CNT_WIDTH'(LENGTH - 1));
      w_stateNext = w_close ? ST_READY : ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_lanes <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_lanes <= w_lanesNext;
    end
  end

  // Token line tracks which tree slots carry a real vector and its length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tokValid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tokCount[i] <= '0;
      end
    end else if (w_advance) begin
      r_tokValid[0] <= w_launch;
      r_tokCount[0] <= w_launch ? r_count : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_tokValid[i] <= r_tokValid[i-1];
        r_tokCount[i] <= r_tokCount[i-1];
      end
    end
  end

  AdderTreePipelined #(
    .DATA_WIDTH (DATA_WIDTH),
    .LENGTH     (LENGTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_tree (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_advance (w_advance),
    .in_data    (r_lanes),
    .out_sum    (w_treeSum)
  );

  assign bus.s_ready = w_sReady;
  assign bus.m_valid = r_tokValid[LATENCY-1];
  assign bus.m_sum   = w_treeSum;
  assign bus.m_count = r_tokCount[LATENCY-1];

endmodule

// File: tb/tb_addend_collector.sv
// Scoreboard bench for addend_collector: directed vectors push hand-computed
// results; an independent monitor compares every presented result in order.
module tb_addend_collector;

  localparam int DW  = 32;
  localparam int LEN = 8;
  localparam int OW  = 35;
  localparam int CW  = 4;

  typedef struct packed {
    logic signed [OW-1:0] sum;
    logic [CW-1:0]        count;
  } result_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  result_t scoreQ[$];
  int      vectors = 0;
  int      miscompares = 0;

  always #5 clk = ~clk;

  addend_collector_if #(.DATA_WIDTH(DW), .LENGTH(LEN)) bus ();

  addend_collector #(
    .DATA_WIDTH (DW),
    .LENGTH     (LEN),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one word from posedge+1 and returns just after the accepting edge.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic last,
                               output int stalls);
    int waitCycles = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    @(negedge clk);
    while (!bus.s_ready && waitCycles < 200) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!bus.s_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL s_ready timeout: got 0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    stalls = waitCycles;
  endtask

  task automatic sendVector(input logic [DW-1:0] words[LEN], input int n,
                            input bit forceLast, input logic signed [OW-1:0] expSum,
                            output int stalls);
    int s;
    result_t r;
    r.sum   = expSum;
    r.count = CW'(n);
    scoreQ.push_back(r);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(words[i], (i == n - 1) && (n < LEN || forceLast), s);
      stalls += s;
    end
  endtask

  task automatic waitDrain();
    int t = 0;
    while (scoreQ.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (scoreQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d results outstanding, expected 0", scoreQ.size());
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle a result is shown it must match the queue head,
  // which also proves the outputs stay frozen while m_ready is low.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_valid) begin
        if (scoreQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected result: got sum 0x%0h, expected none", bus.m_sum);
        end else begin
          checkOutput("m_sum", 64'(bus.m_sum), 64'(scoreQ[0].sum));
          checkOutput("m_count", 64'(bus.m_count), 64'(scoreQ[0].count));
          if (bus.m_ready) void'(scoreQ.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin : stimulus
    logic [DW-1:0] w[LEN];
    int stalls, total, cyc;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("reset m_sum", 64'(bus.m_sum), 64'd0);
    checkOutput("reset m_count", 64'(bus.m_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("s_ready after reset", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Words 1..8, then the launch-to-result latency in advancing edges.
    for (int i = 0; i < LEN; i++) w[i] = DW'(i + 1);
    sendVector(w, 8, 1'b0, 35'sd36, stalls);
    cyc = 0;
    while (!bus.m_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("launch to m_valid edges", 64'(cyc - 1), 64'd3);
    @(posedge clk);
    #1;
    waitDrain();

    // Sign extension and full-scale extremes, back to back.
    total = 0;
    for (int i = 0; i < LEN; i++) w[i] = 32'hFFFF_FFFF;
    sendVector(w, 8, 1'b0, -35'sd8, stalls);
    total += stalls;
    for (int i = 0; i < LEN; i++) w[i] = 32'h7FFF_FFFF;
    sendVector(w, 8, 1'b0, 35'sh3_FFFF_FFF8, stalls);
    total += stalls;

    // Early close with s_last, then a full vector with no gap.
    w[0] = 32'd5; w[1] = 32'd6; w[2] = 32'd7;
    sendVector(w, 3, 1'b0, 35'sd18, stalls);
    total += stalls;
    for (int i = 0; i < LEN; i++) w[i] = DW'(i + 1);
    sendVector(w, 8, 1'b0, 35'sd36, stalls);
    total += stalls;

    // s_last on the final lane closes one vector; single-word vector.
    for (int i = 0; i < LEN; i++) w[i] = DW'(2 * (i + 1));
    sendVector(w, 8, 1'b1, 35'sd72, stalls);
    total += stalls;
    w[0] = -32'sd5;
    sendVector(w, 1, 1'b0, -35'sd5, stalls);
    total += stalls;
    for (int i = 0; i < LEN; i++) w[i] = DW'(i + 1);
    sendVector(w, 8, 1'b0, 35'sd36, stalls);
    total += stalls;
    checkOutput("input stall cycles", 64'(total), 64'd0);
    waitDrain();

    // Backpressure: hold m_ready low for 10 cycles once a result is waiting.
    bus.m_ready = 1'b0;
    total = 0;
    fork
      begin : backpressure
        int t = 0;
        while (!bus.m_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        repeat (10) @(posedge clk);
        #1 bus.m_ready = 1'b1;
      end
      begin : feeder
        logic [DW-1:0] v[LEN];
        int s;
        for (int i = 0; i < LEN; i++) v[i] = DW'(10 + i);
        sendVector(v, 8, 1'b0, 35'sd108, s);
        total += s;
        for (int i = 0; i < LEN; i++) v[i] = DW'(-(i + 1));
        sendVector(v, 8, 1'b0, -35'sd36, s);
        total += s;
        for (int i = 0; i < LEN; i++) v[i] = 32'd16;
        sendVector(v, 8, 1'b0, 35'sd128, s);
        total += s;
      end
    join
    checkOutput("input stalled under backpressure", 64'(total > 0), 64'd1);
    waitDrain();

    // Reset mid-vector discards the partial vector.
    for (int i = 0; i < 4; i++) applyStimulus(32'd9, 1'b0, stalls);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("mid reset m_sum", 64'(bus.m_sum), 64'd0);
    checkOutput("mid reset m_count", 64'(bus.m_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("s_ready after mid reset", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < LEN; i++) w[i] = 32'd1;
    sendVector(w, 8, 1'b0, 35'sd8, stalls);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addend_collector.md
ADDEND_COLLECTOR -- requirements
Module: addend_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one signed addend.
REQ-002 SHALL have parameter LENGTH, default 8, addends per vector; legal range 2..64.
REQ-003 SHALL have parameter OUT_WIDTH, default DATA_WIDTH+clog2(LENGTH), sum width.
REQ-004 SHALL have localparam LATENCY = clog2(LENGTH) and localparam CNT_WIDTH = clog2(LENGTH+1).
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 s_valid  input  1  upstream addend valid.
REQ-009 s_ready  output  1  collector can accept an addend this cycle.
REQ-010 s_data  input  DATA_WIDTH  signed addend.
REQ-011 s_last  input  1  accepted word closes the current vector early.
REQ-012 m_valid  output  1  m_sum/m_count hold a completed result.
REQ-013 m_ready  input  1  downstream accepts the result.
REQ-014 m_sum  output  OUT_WIDTH  signed sum of one vector.
REQ-015 m_count  output  CNT_WIDTH  number of real addends in that vector, 1..LENGTH.

Function
REQ-016 Transfer on either port SHALL occur only on a rising edge with valid&&ready both high.
REQ-017 Global advance SHALL be advance = !m_valid || m_ready; every pipeline stage and token bit SHALL hold when advance=0.
REQ-018 Packing FSM SHALL have states EMPTY (count=0), FILL (0<count<LENGTH, not closed) and READY (vector closed, awaiting launch).
REQ-019 An accepted word SHALL be written to lane count (lane 0 = LSBs), and count SHALL increment.
REQ-020 FILL/EMPTY SHALL go to READY when the accepted word is lane LENGTH-1 or carries s_last; both together SHALL close exactly one vector.
REQ-021 Lanes not written before closing SHALL read as zero in the launched vector.
REQ-022 s_ready SHALL be (state!=READY) || advance; a word accepted in READY while advance=1 SHALL become lane 0 of the next vector in the same edge the closed vector launches.
REQ-023 Launch SHALL occur on the edge where state=READY and advance=1; the packed bus and a token {1,count} SHALL enter the pipeline on that edge; non-launch advancing edges SHALL insert a bubble token {0,x}.
REQ-024 Summation SHALL be a balanced binary tree, one register level per stage, LATENCY levels total, operands sign-extended to each level's width; no overflow is possible at OUT_WIDTH.
REQ-025 m_valid SHALL rise immediately after the LATENCY-th advancing edge counted from and including the launch edge; m_sum and m_count SHALL be registered stage outputs.
REQ-026 While m_valid=1 and m_ready=0, m_sum, m_count and m_valid SHALL stay constant; results SHALL leave in vector order with no loss or duplication.
REQ-027 Sustained throughput with m_ready=1 SHALL be one vector per LENGTH accepted words (no bubble cycle between vectors).

Reset
REQ-028 rst_n low SHALL asynchronously clear FSM to EMPTY, count to 0, lane buffer to 0, all tree registers and tokens to 0.
REQ-029 During and after reset, m_valid=0, m_sum=0, m_count=0; s_ready=1 once rst_n is high.
REQ-030 Reset mid-vector or mid-pipeline SHALL discard all partial and in-flight vectors; no stale result SHALL appear afterwards.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the clog2-derived width helpers.
REQ-032 The summation SHALL be one sub-module instance, AdderTreePipelined (DATA_WIDTH, LENGTH, OUT_WIDTH), with in_advance driven by advance; a matching {valid,count} token shift register of depth LATENCY SHALL live in addend_collector.

Verification (DATA_WIDTH=32, LENGTH=8, LATENCY=3)
REQ-033 Words 1..8 back-to-back, m_ready=1 -> one result m_sum=36, m_count=8, m_valid high exactly 3 advancing edges after launch.
REQ-034 Eight words 0xFFFFFFFF (-1) -> m_sum=-8 (35-bit 0x7FFFFFFF8), m_count=8; eight 0x7FFFFFFF -> m_sum=0x3FFFFFFF8.
REQ-035 Words 5,6,7 with s_last on 7 -> m_sum=18, m_count=3; following vector 1..8 -> 36, no gap cycle.
REQ-036 Continuous input, m_ready low 10 cycles -> m_sum/m_valid frozen, s_ready low once READY, no word lost; on release sums emerge in order.
REQ-037 Four words accepted then rst_n low 2 cycles -> m_valid=0, outputs 0; next vector of eight 1s -> m_sum=8, m_count=8, no earlier result.
